// File: rtl/frame_painter.sv
// Framebuffer writer: snapshots the platforms and player on start, then rasters
// every pixel through a two-stage pipeline onto a valid/ready write port.
module frame_painter #(
    parameter int         PX_WIDTH  = 160,
    parameter int         PX_HEIGHT = 120,
    parameter int         ADDR_W    = 16,
    parameter int         PL_W      = 6,
    parameter logic [2:0] C_BG      = 3'b111,
    parameter logic [2:0] C_SQ      = 3'b010,
    parameter logic [2:0] C_PL      = 3'b100
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [23:0]       square1,
    input  logic [23:0]       square2,
    input  logic [23:0]       square3,
    input  logic [23:0]       player,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam logic [8:0] X_LAST = 9'(PX_WIDTH - 1);
    localparam logic [8:0] Y_LAST = 9'(PX_HEIGHT - 1);
    localparam logic [8:0] PL_W9  = 9'(PL_W);

    state_t state, next_state;

    logic [7:0] sq_cx [3];
    logic [7:0] sq_cy [3];
    logic [7:0] sq_r  [3];
    logic [7:0] pl_x, pl_y, pl_h;

    logic [8:0]        x, y;
    logic [ADDR_W-1:0] addr;

    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [8:0]        s1_dx [3];
    logic [8:0]        s1_dy [3];
    logic              s1_pl;

    logic       advance, last_pixel, start_ok;
    logic [8:0] dx_c [3];
    logic [8:0] dy_c [3];
    logic [8:0] pl_lo, pl_xhi;
    logic       pl_hit_c, sq_hit;
    logic [2:0] colour;

    function automatic logic [8:0] abs_diff(input logic [8:0] a, input logic [8:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // The whole pipeline moves together whenever the output slot can be refilled.
    assign advance    = !wr_en || wr_ready;
    assign last_pixel = (x == X_LAST) && (y == Y_LAST);
    assign start_ok   = (state == IDLE) && start;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SCAN;
            SCAN:    if (advance && last_pixel) next_state = DRAIN;
            DRAIN:   if (wr_en && wr_ready && !s1_valid) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < 3; i++) begin
                sq_cx[i] <= '0;
                sq_cy[i] <= '0;
                sq_r[i]  <= '0;
            end
            pl_x <= '0;
            pl_y <= '0;
            pl_h <= '0;
        end else if (start_ok) begin
            sq_cx[0] <= square1[23:16];
            sq_cy[0] <= square1[15:8];
            sq_r[0]  <= square1[7:0];
            sq_cx[1] <= square2[23:16];
            sq_cy[1] <= square2[15:8];
            sq_r[1]  <= square2[7:0];
            sq_cx[2] <= square3[23:16];
            sq_cy[2] <= square3[15:8];
            sq_r[2]  <= square3[7:0];
            pl_x     <= player[23:16];
            pl_y     <= player[15:8];
            pl_h     <= player[7:0];
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (start_ok) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (state == SCAN && advance) begin
            addr <= addr + ADDR_W'(1);
            if (x == X_LAST) begin
                x <= '0;
                y <= y + 9'd1;
            end else begin
                x <= x + 9'd1;
            end
        end
    end

    // Player bounds stay in 9 bits so px+PL_W and py-h never wrap.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            dx_c[i] = abs_diff(x, {1'b0, sq_cx[i]});
            dy_c[i] = abs_diff(y, {1'b0, sq_cy[i]});
        end
        pl_lo    = (pl_h > pl_y) ? 9'd0 : ({1'b0, pl_y} - {1'b0, pl_h});
        pl_xhi   = {1'b0, pl_x} + PL_W9;
        pl_hit_c = (x >= {1'b0, pl_x}) && (x < pl_xhi) &&
                   (y >= pl_lo) && (y <= {1'b0, pl_y});
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_pl    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                s1_dx[i] <= '0;
                s1_dy[i] <= '0;
            end
        end else if (advance) begin
            s1_valid <= (state == SCAN);
            if (state == SCAN) begin
                s1_addr <= addr;
                s1_pl   <= pl_hit_c;
                for (int i = 0; i < 3; i++) begin
                    s1_dx[i] <= dx_c[i];
                    s1_dy[i] <= dy_c[i];
                end
            end
        end
    end

    always_comb begin
        sq_hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (({1'b0, s1_dx[i]} + {1'b0, s1_dy[i]}) <= {2'b00, sq_r[i]}) begin
                sq_hit = 1'b1;
            end
        end
        if (s1_pl) begin
            colour = C_PL;
        end else if (sq_hit) begin
            colour = C_SQ;
        end else begin
            colour = C_BG;
        end
    end

    // When the output stage drains, address and data keep their last values.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (advance) begin
            wr_en <= s1_valid;
            if (s1_valid) begin
                wr_addr <= s1_addr;
                wr_data <= colour;
            end
        end
    end

endmodule

// File: doc/frame_painter.md
Name: frame_painter

Overview:
- Writer side of the pixel framebuffer. The VGA controller and frame dump read the same buffer through rmemaddr/memout.
- On a start pulse, snapshots the three diamond platforms and the player from the game FSM. It then sweeps every pixel once, in raster order, at one pixel per accepted write.
- Each pixel's 3-bit colour code is written to the framebuffer write port, using a valid/ready handshake toward the memory arbiter.

Parameters:
- PX_WIDTH, 160: pixels per row.
- PX_HEIGHT, 120: rows per frame.
- ADDR_W, 16: framebuffer address width. PX_WIDTH*PX_HEIGHT must be ≤ 2^ADDR_W.
- PL_W, 6: player rectangle width in pixels.
- C_BG, 3'b111: background code.
- C_SQ, 3'b010: platform code.
- C_PL, 3'b100: player code.

Ports:
- clk  in  1  system clock.
- clr  in  1  asynchronous active-low reset.
- start  in  1  single-cycle frame request. Ignored unless idle.
- square1  in  24  {cx[23:16], cy[15:8], r[7:0]}; unsigned pixel units.
- square2  in  24  same format as square1.
- square3  in  24  same format as square1.
- player  in  24  {px[23:16], py[15:8], h[7:0]}; py is the bottom row.
- wr_ready  in  1  memory accepts the write this cycle.
- wr_en  out  1  write valid.
- wr_addr  out  ADDR_W  write address, y*PX_WIDTH+x.
- wr_data  out  3  colour code.
- busy  out  1  high from the start acceptance cycle until done.
- done  out  1  one-cycle pulse after the final write is accepted.

Behaviour:
- Reset (clr low, asynchronous): wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0. FSM goes to IDLE and all pipeline valids clear.
- Reset asserted mid-frame aborts the frame immediately. No done pulse is produced; the next frame needs a new start.
- FSM states: IDLE, SCAN, DRAIN, DONE.
  - IDLE→SCAN when start=1. In that cycle, square1-3 and player are latched into snapshot registers, x=y=0 and addr=0, and busy rises on the next edge.
  - SCAN issues pixels into a 2-stage pipeline:
    - S1 registers |x-cx|, |y-cy| per square (9-bit unsigned abs diff) plus player range flags.
    - S2 registers the colour, addr and valid onto wr_*.
  - SCAN→DRAIN when the last pixel (x=PX_WIDTH-1, y=PX_HEIGHT-1) enters S1.
  - DRAIN→DONE when the S2 holding the last pixel is accepted (wr_en & wr_ready).
  - DONE lasts one cycle, with done=1 and busy dropping to 0 on the following edge, then goes to IDLE.
- Stall: the pipeline advances only when S2 is empty or (wr_en & wr_ready).
  - While stalled, wr_en stays 1 and wr_addr/wr_data are held unchanged.
  - The S1 contents and the x/y counters freeze.
- Latency: with wr_ready tied high, wr_en first rises 2 cycles after the start edge (addr 0). Writes are then one per cycle and contiguous. done is asserted the cycle after the last write.
- Address generation is incremental (addr+1 per advance). No multiplier is used.
- x wraps to 0 and y increments at x=PX_WIDTH-1.
- Colour priority, highest first:
  - Player (C_PL): px ≤ x < px+PL_W and py-h ≤ y ≤ py. Bounds are computed in 9 bits, so no wrap. If h>py, the lower bound clamps to 0.
  - Any square (C_SQ): |x-cx|+|y-cy| ≤ r, with the sum in 10 bits.
  - Otherwise C_BG.
- r=0 draws only the centre pixel. h=0 draws one player row.
- Shapes partly or wholly off-screen are clipped naturally; only in-range pixels are ever addressed.
- Input changes during busy have no effect (snapshot only). start during busy/DONE is dropped, not queued.
- Exactly PX_WIDTH*PX_HEIGHT writes per frame. Each address is written once, in ascending order.

Test Plan:
1. Override PX_WIDTH=8, PX_HEIGHT=6. All squares r=0 at cx=200 (off-screen); player px=200. Pulse start with wr_ready=1 → 48 writes, addr 0..47 in order, all data 3'b111. wr_en first high 2 cycles after start. done pulses the cycle after addr 47. busy is high through done.
2. Same size. square1 = cx 3, cy 2, r 1 → C_SQ exactly at addr 11, 18, 19, 20, 27; all else C_BG.
3. Player px=2, py=4, h=1 overlapping square2 cx 2, cy 4, r 2 → addr 26..31 and 34..39 carry C_PL; the remaining diamond pixels carry C_SQ.
4. Toggle wr_ready low for 3 cycles at addr 5 → wr_addr=5 and wr_data held stable while wr_en=1. No skipped or duplicate address; done is delayed by exactly 3 cycles.
5. Pulse start at addr 10 with square inputs changing → the second start is ignored, the frame uses the original snapshot, and exactly one done pulse occurs.
6. Assert clr low at addr 20 → all outputs 0 asynchronously, no done. A new start after release writes from addr 0.
